ps2_host_ctrl: RTL and testbench

- Host-side PS/2 command sequencer on the same kbd_clk/kbd_dat pair that the scancode receiver listens to.
- Issues keyboard reset (FF) after res_n, then LED updates (ED + mask) on request.
- Handles the host-to-device bus protocol (inhibit, request-to-send, bit shifting, ACK) and device responses (FA/FE/AA) from the receiver's byte stream.
- Masks command responses from the keymap so the ZX matrix never sees them.

---
 rtl/ps2_pkg.sv | 42 ++++
 rtl/ps2_tx_shift.sv | 83 ++++++++
 rtl/ps2_host_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_ps2_host_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and protocol constants for the PS/2 host command sequencer.
package ps2_pkg;

   typedef enum logic [2:0] {
      ST_BOOT,
      ST_INHIBIT,
      ST_TX,
      ST_ACK,
      ST_RESP,
      ST_BAT,
      ST_IDLE,
      ST_ERROR
   } state_e;

   typedef enum logic [2:0] {
      SEQ_RESET,
      SEQ_LED_CMD,
      SEQ_LED_VAL,
      SEQ_RATE_CMD,
      SEQ_RATE_VAL
   } seq_e;

   typedef enum logic [1:0] {
      PH_IDLE,
      PH_DATA,
      PH_ACK
   } tx_phase_e;

   localparam logic [7:0] CMD_RESET    = 8'hFF;
   localparam logic [7:0] CMD_LEDS     = 8'hED;
   localparam logic [7:0] CMD_RATE     = 8'hF3;
   localparam logic [7:0] RSP_ACK      = 8'hFA;
   localparam logic [7:0] RSP_RESEND   = 8'hFE;
   localparam logic [7:0] RSP_BAT_OK   = 8'hAA;
   localparam logic [7:0] RSP_BAT_ERR  = 8'hFC;
   localparam logic [7:0] RATE_DEFAULT = 8'h20;

   function automatic logic odd_parity(input logic [7:0] b);
      return ~^b;
   endfunction

endpackage

// File: rtl/ps2_tx_shift.sv
// Host-to-device PS/2 bit shifter: filtered kbd_clk falling-edge detect,
// d0..d7 + odd parity + stop, then device ACK sample.
module ps2_tx_shift
   import ps2_pkg::*;
(
   input  logic       clk,
   input  logic       res_n,
   input  logic       kbd_clk_i,
   input  logic       kbd_dat_i,
   input  logic       start_i,
   input  logic       abort_i,
   input  logic [7:0] tx_byte_i,
   output logic       dat_oe_o,
   output logic       sent_o,
   output logic       done_o,
   output logic       nack_o
);

   logic [3:0] filt_q;
   logic       lvl_q;
   logic       fall;
   logic [8:0] shreg_q;
   logic [3:0] cnt_q;
   tx_phase_e  phase_q;

   assign fall = lvl_q && (filt_q == 4'b0000);

   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         filt_q   <= '1;
         lvl_q    <= 1'b1;
         shreg_q  <= '0;
         cnt_q    <= '0;
         phase_q  <= PH_IDLE;
         dat_oe_o <= 1'b0;
         sent_o   <= 1'b0;
         done_o   <= 1'b0;
         nack_o   <= 1'b0;
      end else begin
         filt_q <= {filt_q[2:0], kbd_clk_i};
         if (filt_q == 4'b1111)
            lvl_q <= 1'b1;
         else if (filt_q == 4'b0000)
            lvl_q <= 1'b0;

         sent_o <= 1'b0;
         done_o <= 1'b0;
         nack_o <= 1'b0;

         if (abort_i) begin
            phase_q  <= PH_IDLE;
            dat_oe_o <= 1'b0;
         end else if (start_i) begin
            // dat_oe high here is the start bit / request-to-send
            shreg_q  <= {odd_parity(tx_byte_i), tx_byte_i};
            cnt_q    <= '0;
            dat_oe_o <= 1'b1;
            phase_q  <= PH_DATA;
         end else if (fall) begin
            case (phase_q)
               PH_DATA: begin
                  if (cnt_q == 4'd9) begin
                     dat_oe_o <= 1'b0;
                     sent_o   <= 1'b1;
                     phase_q  <= PH_ACK;
                  end else begin
                     dat_oe_o <= ~shreg_q[0];
                     shreg_q  <= {1'b0, shreg_q[8:1]};
                     cnt_q    <= cnt_q + 4'd1;
                  end
               end
               PH_ACK: begin
                  done_o  <= ~kbd_dat_i;
                  nack_o  <= kbd_dat_i;
                  phase_q <= PH_IDLE;
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: rtl/ps2_host_ctrl.sv
// PS/2 host command sequencer: keyboard reset, BAT check, LED updates.
// Define PS2_TYPEMATIC_EN to also program the typematic rate after BAT.
module ps2_host_ctrl
   import ps2_pkg::*;
#(
   parameter int unsigned INHIBIT_CYC = 1400,
   parameter int unsigned TIMEOUT_CYC = 280000,
   parameter int unsigned RETRIES     = 3
) (
   input  logic       clk,
   input  logic       res_n,
   input  logic       kbd_clk,
   input  logic       kbd_dat,
   output logic       kbd_clk_oe,
   output logic       kbd_dat_oe,
   input  logic       rx_ready,
   input  logic [7:0] rx_data,
   input  logic       led_req,
   input  logic [2:0] led_val,
   output logic       rx_mask,
   output logic       busy,
   output logic       init_done,
   output logic       err
);

   localparam int unsigned CMAX = (TIMEOUT_CYC > INHIBIT_CYC) ? TIMEOUT_CYC : INHIBIT_CYC;
   localparam int unsigned CW   = $clog2(CMAX + 1);
   localparam int unsigned RW   = $clog2(RETRIES + 1);

   state_e        state_q;
   seq_e          seq_q;
   logic [CW-1:0] cnt_q;
   logic [RW-1:0] tries_q;
   logic [7:0]    byte_q;
   logic [2:0]    led_q, pend_val_q;
   logic          pend_q, clk_oe_q, rx_mask_q, busy_q, init_done_q, err_q;
   logic          tx_start, tmo, fail, tx_dat_oe, tx_sent, tx_done, tx_nack;

   always_comb begin
      tx_start = (state_q == ST_INHIBIT) && (cnt_q == CW'(INHIBIT_CYC - 1));
      tmo      = (state_q inside {ST_TX, ST_ACK, ST_RESP, ST_BAT}) &&
                 (cnt_q == CW'(TIMEOUT_CYC - 1));
      fail     = tmo || ((state_q == ST_ACK) && tx_nack) ||
                 ((state_q == ST_RESP) && rx_ready && (rx_data == RSP_RESEND));
   end

   ps2_tx_shift u_shift (
      .clk       (clk),
      .res_n     (res_n),
      .kbd_clk_i (kbd_clk),
      .kbd_dat_i (kbd_dat),
      .start_i   (tx_start),
      .abort_i   (fail),
      .tx_byte_i (byte_q),
      .dat_oe_o  (tx_dat_oe),
      .sent_o    (tx_sent),
      .done_o    (tx_done),
      .nack_o    (tx_nack)
   );

   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         state_q     <= ST_BOOT;
         seq_q       <= SEQ_RESET;
         cnt_q       <= '0;
         tries_q     <= '0;
         byte_q      <= '0;
         led_q       <= '0;
         pend_val_q  <= '0;
         pend_q      <= 1'b0;
         clk_oe_q    <= 1'b0;
         rx_mask_q   <= 1'b0;
         busy_q      <= 1'b0;
         init_done_q <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         if (led_req && (state_q != ST_IDLE) && (state_q != ST_ERROR)) begin
            pend_q     <= 1'b1;
            pend_val_q <= led_val;
         end
         cnt_q <= cnt_q + CW'(1);

         if (fail) begin
            // Every failed try restarts from INHIBIT with the same byte
            cnt_q <= '0;
            if (tries_q == RW'(RETRIES - 1)) begin
               state_q   <= ST_ERROR;
               err_q     <= 1'b1;
               rx_mask_q <= 1'b0;
               clk_oe_q  <= 1'b0;
            end else begin
               tries_q  <= tries_q + RW'(1);
               state_q  <= ST_INHIBIT;
               clk_oe_q <= 1'b1;
            end
         end else begin
            case (state_q)
               ST_BOOT: begin
                  byte_q    <= CMD_RESET;
                  seq_q     <= SEQ_RESET;
                  tries_q   <= '0;
                  cnt_q     <= '0;
                  clk_oe_q  <= 1'b1;
                  rx_mask_q <= 1'b1;
                  busy_q    <= 1'b1;
                  state_q   <= ST_INHIBIT;
               end
               ST_INHIBIT: if (tx_start) begin
                  cnt_q   <= '0;
                  state_q <= ST_TX;
               end
               ST_TX: begin
                  // clk released only once data is already pulled low
                  if (tx_dat_oe) clk_oe_q <= 1'b0;
                  if (tx_sent) begin
                     cnt_q   <= '0;
                     state_q <= ST_ACK;
                  end
               end
               ST_ACK: if (tx_done) begin
                  cnt_q   <= '0;
                  state_q <= ST_RESP;
               end
               ST_RESP: if (rx_ready && (rx_data == RSP_ACK)) begin
                  cnt_q   <= '0;
                  tries_q <= '0;
                  case (seq_q)
                     SEQ_RESET: state_q <= ST_BAT;
                     SEQ_LED_CMD: begin
                        byte_q   <= {5'b0, led_q};
                        seq_q    <= SEQ_LED_VAL;
                        clk_oe_q <= 1'b1;
                        state_q  <= ST_INHIBIT;
                     end
                     SEQ_RATE_CMD: begin
                        byte_q   <= RATE_DEFAULT;
                        seq_q    <= SEQ_RATE_VAL;
                        clk_oe_q <= 1'b1;
                        state_q  <= ST_INHIBIT;
                     end
                     SEQ_RATE_VAL: begin
                        init_done_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= ST_IDLE;
                     end
                     default: begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                     end
                  endcase
               end
               ST_BAT: if (rx_ready) begin
                  if (rx_data == RSP_BAT_OK) begin
                     cnt_q <= '0;
`ifdef PS2_TYPEMATIC_EN
                     byte_q   <= CMD_RATE;
                     seq_q    <= SEQ_RATE_CMD;
                     clk_oe_q <= 1'b1;
                     state_q  <= ST_INHIBIT;
`else
                     init_done_q <= 1'b1;
                     busy_q      <= 1'b0;
                     state_q     <= ST_IDLE;
`endif
                  end else if (rx_data == RSP_BAT_ERR) begin
                     err_q     <= 1'b1;
                     rx_mask_q <= 1'b0;
                     state_q   <= ST_ERROR;
                  end
               end
               ST_IDLE: begin
                  cnt_q     <= '0;
                  rx_mask_q <= 1'b0;
                  if (led_req || pend_q) begin
                     led_q     <= led_req ? led_val : pend_val_q;
                     pend_q    <= 1'b0;
                     byte_q    <= CMD_LEDS;
                     seq_q     <= SEQ_LED_CMD;
                     tries_q   <= '0;
                     clk_oe_q  <= 1'b1;
                     rx_mask_q <= 1'b1;
                     busy_q    <= 1'b1;
                     state_q   <= ST_INHIBIT;
                  end
               end
               ST_ERROR: begin
                  cnt_q     <= '0;
                  clk_oe_q  <= 1'b0;
                  rx_mask_q <= 1'b0;
               end
               default: state_q <= ST_BOOT;
            endcase
         end
      end
   end

   assign kbd_clk_oe = clk_oe_q;
   assign kbd_dat_oe = tx_dat_oe;
   assign rx_mask    = rx_mask_q;
   assign busy       = busy_q;
   assign init_done  = init_done_q;
   assign err        = err_q;

endmodule

// File: tb/tb_ps2_host_ctrl.sv
// Bench for ps2_host_ctrl: open-drain bus with a PS/2 device model and a
// queue-based model of the expected host command byte stream.
module tb_ps2_host_ctrl;

   logic       clk = 1'b0;
   logic       res_n = 1'b0;
   logic       dev_clk = 1'b1, dev_dat = 1'b1;
   logic       rx_ready = 1'b0;
   logic [7:0] rx_data = '0;
   logic       led_req = 1'b0;
   logic [2:0] led_val = '0;
   logic       kbd_clk_oe, kbd_dat_oe, rx_mask, busy, init_done, err;
   logic       kbd_clk_line, kbd_dat_line;

   int vectors = 0, miscompares = 0;
   int run = 0, max_run = 0, inh_cnt = 0;
   logic prev_clk_oe = 1'b0;

   logic [7:0] exp_q[$];
   logic [2:0] pend = '0;
   bit         pend_valid = 1'b0;

   assign kbd_clk_line = dev_clk & ~kbd_clk_oe;
   assign kbd_dat_line = dev_dat & ~kbd_dat_oe;

   ps2_host_ctrl #(.INHIBIT_CYC(40), .TIMEOUT_CYC(3000), .RETRIES(3)) dut (
      .clk        (clk),
      .res_n      (res_n),
      .kbd_clk    (kbd_clk_line),
      .kbd_dat    (kbd_dat_line),
      .kbd_clk_oe (kbd_clk_oe),
      .kbd_dat_oe (kbd_dat_oe),
      .rx_ready   (rx_ready),
      .rx_data    (rx_data),
      .led_req    (led_req),
      .led_val    (led_val),
      .rx_mask    (rx_mask),
      .busy       (busy),
      .init_done  (init_done),
      .err        (err)
   );

   always #5 clk = ~clk;

   // Longest stretch with both lines driven, and count of inhibit phases
   always @(negedge clk) begin
      if (kbd_clk_oe && kbd_dat_oe) run++;
      else run = 0;
      if (run > max_run) max_run = run;
      if (kbd_clk_oe && !prev_clk_oe) inh_cnt++;
      prev_clk_oe = kbd_clk_oe;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      exp_q.push_back(8'hFF);
      pend_valid = 1'b0;
   endtask

   task automatic led_pulse(input logic [2:0] v);
      if (exp_q.size() != 0) begin
         pend = v;
         pend_valid = 1'b1;
      end else begin
         exp_q.push_back(8'hED);
         exp_q.push_back({5'b0, v});
      end
      led_req = 1'b1;
      led_val = v;
      @(negedge clk);
      led_req = 1'b0;
   endtask

   task automatic send_rsp(input logic [7:0] b);
      rx_ready = 1'b1;
      rx_data  = b;
      @(negedge clk);
      rx_ready = 1'b0;
   endtask

   // Device side of one host-to-device frame; cut>0 stops while the clock
   // is low after that falling edge.
   task automatic recv_byte(input int cut, input bit ack_low,
                            output logic [9:0] bits, output bit ok);
      int hp;
      ok = 1'b0;
      bits = '0;
      for (int i = 0; i < 20000 && !(kbd_dat_oe && !kbd_clk_oe); i++) @(negedge clk);
      if (!(kbd_dat_oe && !kbd_clk_oe)) return;
      repeat (10) @(negedge clk);
      for (int k = 1; k <= 10; k++) begin
         hp = $urandom_range(25, 12);
         dev_clk = 1'b0;
         repeat (hp) @(negedge clk);
         if (k == cut) begin
            ok = 1'b1;
            return;
         end
         bits[k-1] = kbd_dat_line;
         dev_clk = 1'b1;
         repeat (hp) @(negedge clk);
      end
      hp = $urandom_range(25, 12);
      dev_dat = ~ack_low;
      repeat (5) @(negedge clk);
      dev_clk = 1'b0;
      repeat (hp) @(negedge clk);
      dev_clk = 1'b1;
      repeat (hp) @(negedge clk);
      dev_dat = 1'b1;
      ok = 1'b1;
   endtask

   task automatic xfer_next(input int nfe);
      logic [7:0] e;
      logic [9:0] bits;
      bit ok;
      e = exp_q.pop_front();
      if (exp_q.size() == 0 && pend_valid) begin
         exp_q.push_back(8'hED);
         exp_q.push_back({5'b0, pend});
         pend_valid = 1'b0;
      end
      for (int t = 0; t <= nfe; t++) begin
         recv_byte(0, 1'b1, bits, ok);
         check("frame_seen", {31'b0, ok}, 1);
         check("tx_byte", {24'b0, bits[7:0]}, {24'b0, e});
         check("tx_parity", {31'b0, bits[8]}, ($countones(e) % 2 == 0) ? 1 : 0);
         check("tx_stop", {31'b0, bits[9]}, 1);
         check("rx_mask_active", {31'b0, rx_mask}, 1);
         send_rsp((t < nfe) ? 8'hFE : 8'hFA);
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 8 && exp_q.size() != 0; i++) xfer_next(0);
   endtask

   task automatic boot_seq();
      xfer_next(0);
      check("init_before_bat", {31'b0, init_done}, 0);
      send_rsp(8'hAA);
`ifdef PS2_TYPEMATIC_EN
      exp_q.push_back(8'hF3);
      exp_q.push_back(8'h20);
      drain();
`endif
      check("init_done", {31'b0, init_done}, 1);
      check("boot_busy", {31'b0, busy}, 0);
      @(negedge clk);
      check("boot_rx_mask", {31'b0, rx_mask}, 0);
   endtask

   initial begin
      logic [9:0] bits;
      bit ok;
      int base;
      logic [2:0] v;

      repeat (3) @(negedge clk);
      check("rst_clk_oe", {31'b0, kbd_clk_oe}, 0);
      check("rst_dat_oe", {31'b0, kbd_dat_oe}, 0);
      check("rst_rx_mask", {31'b0, rx_mask}, 0);
      check("rst_busy", {31'b0, busy}, 0);
      check("rst_init", {31'b0, init_done}, 0);
      check("rst_err", {31'b0, err}, 0);
      model_reset();
      res_n = 1'b1;
      boot_seq();

      led_pulse(3'b101);
      drain();
      check("led_busy", {31'b0, busy}, 0);
      @(negedge clk);
      check("led_rx_mask", {31'b0, rx_mask}, 0);

      base = inh_cnt;
      v = 3'($urandom_range(7, 0));
      led_pulse(v);
      xfer_next(2);
      drain();
      check("fe_err", {31'b0, err}, 0);
      check("fe_tries", inh_cnt - base, 4);

      repeat (5) @(negedge clk);
      base = inh_cnt;
      v = 3'($urandom_range(7, 0));
      led_pulse(v);
      repeat (3) @(negedge clk);
      led_pulse(3'b001);
      repeat (3) @(negedge clk);
      led_pulse(3'b100);
      drain();
      repeat (300) @(negedge clk);
      check("pend_frames", inh_cnt - base, 4);
      check("pend_busy", {31'b0, busy}, 0);

      v = 3'($urandom_range(7, 0));
      led_pulse(v);
      recv_byte(5, 1'b1, bits, ok);
      check("mid_frame_seen", {31'b0, ok}, 1);
      check("mid_dat_oe", {31'b0, kbd_dat_oe}, 1);
      #3 res_n = 1'b0;
      #1;
      check("async_clk_oe", {31'b0, kbd_clk_oe}, 0);
      check("async_dat_oe", {31'b0, kbd_dat_oe}, 0);
      dev_clk = 1'b1;
      repeat (2) @(negedge clk);
      model_reset();
      res_n = 1'b1;
      boot_seq();

      base = inh_cnt;
      v = 3'($urandom_range(7, 0));
      led_pulse(v);
      for (int i = 0; i < 15000 && !err; i++) @(negedge clk);
      check("to_err", {31'b0, err}, 1);
      check("to_tries", inh_cnt - base, 3);
      check("to_clk_oe", {31'b0, kbd_clk_oe}, 0);
      check("to_dat_oe", {31'b0, kbd_dat_oe}, 0);
      check("to_rx_mask", {31'b0, rx_mask}, 0);
      repeat (500) @(negedge clk);
      check("to_stays", inh_cnt - base, 3);
      check("to_err_sticky", {31'b0, err}, 1);

      check("oe_overlap", max_run, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
